// File: rtl/decl_check.sv
// rtl/decl_check.sv - character-serial checker for "int"/"char" declaration statements
//
// Consumes one ASCII character per clock while in_valid is high and checks it
// against: WS* TYPE WS+ ID (WS* ',' WS* ID)* WS* ';'
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   in        ASCII character, consumed when in_valid is high
//   in_valid  character qualifier; when low all state holds
//   out       one-cycle pulse after the ';' of a legal declaration
//   err       one-cycle pulse after the ';' of an illegal statement
//   is_char   type of the last legal declaration (0 = int, 1 = char)
//   id_num    identifier count of the last legal declaration
//   decl_cnt  saturating count of legal declarations
module decl_check #(
  parameter int MAX_ID_LEN = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             out,
  output logic             err,
  output logic             is_char,
  output logic [CNT_W-1:0] id_num,
  output logic [CNT_W-1:0] decl_cnt
);

  // Length register must hold MAX_ID_LEN and also the keyword lengths 3 and 4.
  localparam int LEN_RAW = $clog2(MAX_ID_LEN + 2);
  localparam int LEN_W   = (LEN_RAW < 3) ? 3 : LEN_RAW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KW,
    S_KWGAP,
    S_PRE,
    S_ID,
    S_POST,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic             kw_sel_q, kw_sel_d;     // 0 = "int", 1 = "char"
  logic [1:0]       kw_pos_q, kw_pos_d;     // keyword characters matched so far
  logic [LEN_W-1:0] id_len_q, id_len_d;
  logic [CNT_W-1:0] id_cnt_q, id_cnt_d;
  logic             m_int_q, m_int_d;       // identifier so far is a prefix of "int"
  logic             m_char_q, m_char_d;     // identifier so far is a prefix of "char"
  logic             out_q, out_d;
  logic             err_q, err_d;
  logic             is_char_q, is_char_d;
  logic [CNT_W-1:0] id_num_q, id_num_d;
  logic [CNT_W-1:0] decl_cnt_q, decl_cnt_d;

  logic is_ws, is_semi, is_comma, is_alpha, is_digit, id_start, id_char;
  logic id_is_kw, legal_end;

  function automatic logic [7:0] kw_letter(input logic sel, input logic [1:0] pos);
    logic [7:0] c;
    case ({sel, pos})
      3'b000:  c = "i";
      3'b001:  c = "n";
      3'b010:  c = "t";
      3'b100:  c = "c";
      3'b101:  c = "h";
      3'b110:  c = "a";
      3'b111:  c = "r";
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign is_ws    = (in == 8'd32) || (in == 8'd9);
  assign is_semi  = (in == ";");
  assign is_comma = (in == ",");
  assign is_alpha = ((in >= "a") && (in <= "z")) || ((in >= "A") && (in <= "Z"));
  assign is_digit = (in >= "0") && (in <= "9");
  assign id_start = is_alpha || (in == "_");
  assign id_char  = id_start || is_digit;

  // An identifier spelling exactly a keyword is rejected when it terminates.
  assign id_is_kw  = (m_int_q && (id_len_q == LEN_W'(3))) ||
                     (m_char_q && (id_len_q == LEN_W'(4)));
  assign legal_end = (state_q == S_POST) || ((state_q == S_ID) && !id_is_kw);

  always_comb begin
    state_d    = state_q;
    kw_sel_d   = kw_sel_q;
    kw_pos_d   = kw_pos_q;
    id_len_d   = id_len_q;
    id_cnt_d   = id_cnt_q;
    m_int_d    = m_int_q;
    m_char_d   = m_char_q;
    out_d      = 1'b0;
    err_d      = 1'b0;
    is_char_d  = is_char_q;
    id_num_d   = id_num_q;
    decl_cnt_d = decl_cnt_q;

    if (in_valid) begin
      if (is_semi) begin
        // Every ';' resynchronises; only a ';' outside IDLE produces a pulse.
        state_d  = S_IDLE;
        id_cnt_d = '0;
        id_len_d = '0;
        if (state_q != S_IDLE) begin
          if (legal_end) begin
            out_d      = 1'b1;
            is_char_d  = kw_sel_q;
            id_num_d   = id_cnt_q;
            decl_cnt_d = sat_inc(decl_cnt_q);
          end else begin
            err_d = 1'b1;
          end
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (in == "i") begin
              state_d  = S_KW;
              kw_sel_d = 1'b0;
              kw_pos_d = 2'd1;
            end else if (in == "c") begin
              state_d  = S_KW;
              kw_sel_d = 1'b1;
              kw_pos_d = 2'd1;
            end else if (!is_ws) begin
              state_d = S_ERR;
            end
          end
          S_KW: begin
            // The last keyword letter lands in KWGAP, which then demands WS.
            if (in == kw_letter(kw_sel_q, kw_pos_q)) begin
              if (kw_pos_q == (kw_sel_q ? 2'd3 : 2'd2)) begin
                state_d = S_KWGAP;
              end else begin
                kw_pos_d = kw_pos_q + 2'd1;
              end
            end else begin
              state_d = S_ERR;
            end
          end
          S_KWGAP: begin
            state_d = is_ws ? S_PRE : S_ERR;
          end
          S_PRE: begin
            if (id_start) begin
              state_d  = S_ID;
              id_len_d = LEN_W'(1);
              id_cnt_d = sat_inc(id_cnt_q);
              m_int_d  = (in == "i");
              m_char_d = (in == "c");
            end else if (!is_ws) begin
              state_d = S_ERR;
            end
          end
          S_ID: begin
            if (id_char) begin
              if (id_len_q == LEN_W'(MAX_ID_LEN)) begin
                state_d = S_ERR;
              end else begin
                id_len_d = id_len_q + 1'b1;
                m_int_d  = m_int_q && (id_len_q < LEN_W'(3)) &&
                           (in == kw_letter(1'b0, id_len_q[1:0]));
                m_char_d = m_char_q && (id_len_q < LEN_W'(4)) &&
                           (in == kw_letter(1'b1, id_len_q[1:0]));
              end
            end else if (is_ws) begin
              state_d = id_is_kw ? S_ERR : S_POST;
            end else if (is_comma) begin
              state_d = id_is_kw ? S_ERR : S_PRE;
            end else begin
              state_d = S_ERR;
            end
          end
          S_POST: begin
            if (is_comma) begin
              state_d = S_PRE;
            end else if (!is_ws) begin
              state_d = S_ERR;
            end
          end
          default: begin
            state_d = S_ERR;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      kw_sel_q   <= 1'b0;
      kw_pos_q   <= 2'd0;
      id_len_q   <= '0;
      id_cnt_q   <= '0;
      m_int_q    <= 1'b0;
      m_char_q   <= 1'b0;
      out_q      <= 1'b0;
      err_q      <= 1'b0;
      is_char_q  <= 1'b0;
      id_num_q   <= '0;
      decl_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      kw_sel_q   <= kw_sel_d;
      kw_pos_q   <= kw_pos_d;
      id_len_q   <= id_len_d;
      id_cnt_q   <= id_cnt_d;
      m_int_q    <= m_int_d;
      m_char_q   <= m_char_d;
      out_q      <= out_d;
      err_q      <= err_d;
      is_char_q  <= is_char_d;
      id_num_q   <= id_num_d;
      decl_cnt_q <= decl_cnt_d;
    end
  end

  assign out      = out_q;
  assign err      = err_q;
  assign is_char  = is_char_q;
  assign id_num   = id_num_q;
  assign decl_cnt = decl_cnt_q;

endmodule
